// File: rtl/instruction_fetch.sv
// Instruction fetch: in-order imem requests, prefetch FIFO of {pc, word}, and a
// redirect path that flushes buffered words and drains stale in-flight responses.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] instruction,
  output logic [31:0] inst_pc
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } fetch_ent_t;

  fetch_ent_t [FIFO_DEPTH-1:0] fifo_q;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, outstanding, drop_cnt;
  logic [31:0]   fetch_pc, rsp_pc, redir_pc;
  logic [CW:0]   inflight;
  logic          credit, req_fire, push, pop, rsp_drop;

  assign redir_pc = redirect_pc & 32'hFFFF_FFFC;

  // Every accepted request is guaranteed a FIFO slot, so responses never stall.
  assign inflight       = {1'b0, outstanding} + {1'b0, count};
  assign credit         = inflight < (CW+1)'(FIFO_DEPTH);
  assign imem_req_valid = credit & ~redirect_valid & ~rst;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign rsp_drop   = imem_rsp_valid & (drop_cnt != '0);
  assign push       = imem_rsp_valid & (drop_cnt == '0) & ~redirect_valid;
  assign inst_valid = (count != '0);
  assign pop        = inst_valid & inst_ready;

  assign instruction = inst_valid ? fifo_q[rd_ptr].word : '0;
  assign inst_pc     = inst_valid ? fifo_q[rd_ptr].pc   : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else if (redirect_valid) begin
      // No request fires this cycle; whatever is still due after today's
      // response belongs to the old path.
      fetch_pc    <= redir_pc;
      rsp_pc      <= redir_pc;
      outstanding <= outstanding - CW'(imem_rsp_valid);
      drop_cnt    <= outstanding - CW'(imem_rsp_valid);
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + 32'd4;
      if (push) begin
        rsp_pc <= rsp_pc + 32'd4;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rsp_drop) drop_cnt <= drop_cnt - CW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      count       <= count + CW'(push) - CW'(pop);
    end
  end

  // Payload storage needs no reset; count qualifies every read.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= '{pc: rsp_pc, word: imem_rsp_data};
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    push |-> (count != CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized bench for instruction_fetch: latency-programmable memory model,
// request-address model, and a scoreboard of expected {pc, word} per fetch path.
module tb_instruction_fetch;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid, inst_ready;
  logic [31:0] instruction, inst_pc;

  always #5 clk = ~clk;

  instruction_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .instruction(instruction), .inst_pc(inst_pc)
  );

  typedef struct { logic [31:0] pc; logic [31:0] word; } exp_t;
  typedef struct { int due; logic [31:0] addr; } mreq_t;

  exp_t  exp_q[$];
  mreq_t mem_q[$];
  int checks = 0, errors = 0, cyc = 0, acc_cnt = 0, delivered = 0;
  int lat = 1, ready_mode = 1, inst_mode = 1;
  logic [31:0] exp_req_pc = RESET_PC;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected delivery stream of a fetch path: sequential words from its start.
  function automatic void refill(input logic [31:0] pc);
    logic [31:0] a;
    a = pc & 32'hFFFF_FFFC;
    exp_q.delete();
    for (int i = 0; i < 512; i++) begin
      exp_q.push_back('{pc: a, word: mem_word(a)});
      a = a + 32'd4;
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    case (inst_mode)
      0:       inst_ready = 1'b0;
      1:       inst_ready = 1'b1;
      default: inst_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Memory model plus request-side checks.
  logic        prev_pend = 1'b0;
  logic [31:0] prev_addr = '0;
  always @(negedge clk) begin
    mreq_t h;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      h = mem_q.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(h.addr);
    end
    case (ready_mode)
      0:       imem_req_ready = 1'b0;
      1:       imem_req_ready = 1'b1;
      default: imem_req_ready = 1'($urandom_range(0, 1));
    endcase
    #1;
    if (rst) begin
      mem_q.delete();
      exp_req_pc = RESET_PC;
      prev_pend  = 1'b0;
    end else begin
      if (redirect_valid) chk("req_blocked_on_redirect", 32'(imem_req_valid), 32'd0);
      else if (prev_pend) begin
        chk("req_hold_valid", 32'(imem_req_valid), 32'd1);
        chk("req_hold_addr", imem_req_addr, prev_addr);
      end
      if (imem_req_valid && imem_req_ready) begin
        chk("req_addr", imem_req_addr, exp_req_pc);
        exp_req_pc = exp_req_pc + 32'd4;
        acc_cnt++;
        mem_q.push_back('{due: cyc + lat, addr: imem_req_addr});
      end
      prev_pend = imem_req_valid && !imem_req_ready;
      prev_addr = imem_req_addr;
      if (redirect_valid) begin
        exp_req_pc = redirect_pc & 32'hFFFF_FFFC;
        prev_pend  = 1'b0;
      end
    end
  end

  // Delivery monitor: pops the scoreboard on every decode handshake.
  logic        prev_hold = 1'b0;
  logic [31:0] hold_pc = '0, hold_word = '0;
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (rst) prev_hold = 1'b0;
    else begin
      if (prev_hold) begin
        chk("head_stable_valid", 32'(inst_valid), 32'd1);
        chk("head_stable_pc", inst_pc, hold_pc);
        chk("head_stable_word", instruction, hold_word);
      end
      if (!inst_valid) begin
        chk("idle_instruction_zero", instruction, 32'd0);
        chk("idle_inst_pc_zero", inst_pc, 32'd0);
      end
      if (inst_valid && inst_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty: got pc 0x%08h expected no delivery", inst_pc);
        end else begin
          e = exp_q.pop_front();
          chk("inst_pc", inst_pc, e.pc);
          chk("instruction", instruction, e.word);
        end
        delivered++;
      end
      prev_hold = inst_valid && !inst_ready && !redirect_valid;
      hold_pc   = inst_pc;
      hold_word = instruction;
    end
  end

  task automatic chk_reset_outputs();
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_instruction", instruction, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_req_addr", imem_req_addr, RESET_PC);
  endtask

  // Returns at the release negedge (cycle 0 of the new run).
  task automatic do_reset(input bit mid);
    @(negedge clk);
    if (mid) begin #3; rst = 1'b1; #1; end
    else begin rst = 1'b1; #2; end
    chk_reset_outputs();
    refill(RESET_PC);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_redirect(input logic [31:0] pc, input bit lat_chk);
    logic [31:0] tgt;
    tgt = pc & 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    #2;
    if (lat_chk) begin
      chk("redir_rsp_overlap", 32'(imem_rsp_valid), 32'd1);
      chk("redir_handshake", 32'(inst_valid && inst_ready), 32'd1);
    end
    refill(pc);
    @(negedge clk);
    redirect_valid = 1'b0;
    if (lat_chk) begin
      #2;
      chk("redir_r1_inst_valid", 32'(inst_valid), 32'd0);
      chk("redir_r1_req_valid", 32'(imem_req_valid), 32'd1);
      chk("redir_r1_req_addr", imem_req_addr, tgt);
      @(negedge clk); #2;
      chk("redir_r2_inst_valid", 32'(inst_valid), 32'd0);
      @(negedge clk); #2;
      chk("redir_r3_inst_valid", 32'(inst_valid), 32'd1);
      chk("redir_r3_inst_pc", inst_pc, tgt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, a0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    refill(RESET_PC);

    // Reset release, L=1, full rate.
    repeat (2) @(negedge clk);
    #2 chk_reset_outputs();
    @(negedge clk); rst = 1'b0;
    #2;
    chk("first_req_valid", 32'(imem_req_valid), 32'd1);
    chk("first_req_addr", imem_req_addr, RESET_PC);
    @(negedge clk); #2 chk("first_c1_inst_valid", 32'(inst_valid), 32'd0);
    @(negedge clk); #2;
    chk("first_c2_inst_valid", 32'(inst_valid), 32'd1);
    chk("first_inst_pc", inst_pc, RESET_PC);
    d0 = delivered;
    repeat (20) @(negedge clk);
    #2 chk("full_rate_count", 32'(delivered - d0), 32'd20);

    // Back-pressure: exactly FIFO_DEPTH requests, then stall with a stable head.
    inst_mode = 0;
    do_reset(0);
    a0 = acc_cnt;
    #2;
    repeat (9) @(negedge clk);
    #2;
    chk("bp_accepts", 32'(acc_cnt - a0), 32'(FIFO_DEPTH));
    chk("bp_req_valid", 32'(imem_req_valid), 32'd0);
    chk("bp_inst_valid", 32'(inst_valid), 32'd1);
    chk("bp_head_pc", inst_pc, 32'h0);
    inst_mode = 1;
    d0 = delivered;
    repeat (12) @(negedge clk);
    #2 chk("bp_resume", 32'(delivered - d0 >= 8), 32'd1);

    // L=3, two requests in flight, redirect to 0x100.
    lat = 3;
    do_reset(0);
    @(negedge clk);
    do_redirect(32'h0000_0100, 1'b0);
    d0 = delivered;
    repeat (15) @(negedge clk);
    #2 chk("l3_redirect_progress", 32'(delivered - d0 > 0), 32'd1);

    // Redirect coinciding with a response and a decode handshake, L=1.
    lat = 1;
    do_reset(0);
    repeat (8) @(negedge clk);
    do_redirect(32'h0000_4A40, 1'b1);
    repeat (6) @(negedge clk);

    // Random memory ready, then redirect to an unaligned target.
    lat = 2; ready_mode = 2; inst_mode = 2;
    repeat (60) @(negedge clk);
    do_redirect(32'h0000_0203, 1'b0);
    #2 chk("restart_addr", imem_req_addr, 32'h0000_0200);
    repeat (60) @(negedge clk);

    // Fully randomized traffic, including an address-space wrap.
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) lat = $urandom_range(1, 3);
      if (i == 200) do_redirect(32'hFFFF_FFF6, 1'b0);
      else if ($urandom_range(0, 19) == 0) do_redirect($urandom, 1'b0);
      else @(negedge clk);
    end

    // Asynchronous reset with the FIFO partly full.
    lat = 1; ready_mode = 1; inst_mode = 0;
    do_reset(0);
    repeat (3) @(negedge clk);
    #2 chk("pre_rst_fill", 32'(inst_valid), 32'd1);
    do_reset(1);
    inst_mode = 1;
    #2;
    chk("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
    chk("post_rst_req_addr", imem_req_addr, RESET_PC);
    d0 = delivered;
    repeat (20) @(negedge clk);
    #2 chk("post_rst_progress", 32'(delivered - d0 >= 15), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
